// File: rtl/dut_seq_if.sv
// -----------------------------------------------------------------------------
// dut_seq_if: the FIFO handshake bundle between the sequencer and the
// command, stimulus and result FIFOs.
//   dififo_data    command FIFO read data (valid the cycle after dififo_rdreq)
//   dififo_rdempty command FIFO empty
//   dififo_rdreq   command FIFO read strobe
//   sfifo_rdempty  stimulus FIFO empty
//   sfifo_rdreq    stimulus FIFO read strobe, one per vector
//   rfifo_wrreq    result FIFO write strobe, retires one outstanding vector
//   rfifo_wrfull   result FIFO full
// The master modport is the sequencer; the slave modport is the FIFO side.
// -----------------------------------------------------------------------------
interface dut_seq_if #(
  parameter int DIF_WIDTH = 32
);
  logic [DIF_WIDTH-1:0] dififo_data;
  logic                 dififo_rdempty;
  logic                 dififo_rdreq;
  logic                 sfifo_rdempty;
  logic                 sfifo_rdreq;
  logic                 rfifo_wrreq;
  logic                 rfifo_wrfull;

  modport master (
    input  dififo_data, dififo_rdempty, sfifo_rdempty, rfifo_wrreq, rfifo_wrfull,
    output dififo_rdreq, sfifo_rdreq
  );

  modport slave (
    output dififo_data, dififo_rdempty, sfifo_rdempty, rfifo_wrreq, rfifo_wrfull,
    input  dififo_rdreq, sfifo_rdreq
  );
endinterface

// File: rtl/dut_seq.sv
// -----------------------------------------------------------------------------
// dut_seq: command-driven test sequencer. Fetches command words, programs the
// per-pin clock mux, streams a counted number of stimulus vectors while
// limiting how many are in flight, and drains in-flight vectors on request.
//
// Ports:
//   clock_gated  clock, rising edge
//   reset_n      asynchronous active-low reset
//   fifo         dut_seq_if.master: command/stimulus/result FIFO handshakes
//   mux_config   registered per-pin clock-mux select
//   mux_load     one-cycle pulse on the cycle mux_config changes
//   busy         high whenever the FSM is not in IDLE
//   err_cmd      sticky: unknown opcode seen
//   err_timeout  sticky: drain watchdog expired
//
// Commands (opcode in the top CMD_WIDTH bits, payload in the low STF_WIDTH):
//   0x01 SETUP_MUXES  mux_config <= payload
//   0x02 RUN          issue payload[CNT_WIDTH-1:0] stimulus reads
//   0x03 WAIT         wait until every issued vector has a result
//
// Build option: define DUT_SEQ_TIMEOUT_EN to add a drain watchdog that gives
// up after TIMEOUT_CYCLES cycles in DRAIN; without it err_timeout is tied low
// and DRAIN waits indefinitely. CNT_WIDTH must not exceed STF_WIDTH.
// -----------------------------------------------------------------------------
module dut_seq #(
  parameter int STF_WIDTH      = 24,
  parameter int CMD_WIDTH      = 8,
  parameter int DIF_WIDTH      = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int MAX_OUT        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock_gated,
  input  logic                 reset_n,
  dut_seq_if.master            fifo,
  output logic [STF_WIDTH-1:0] mux_config,
  output logic                 mux_load,
  output logic                 busy,
  output logic                 err_cmd,
  output logic                 err_timeout
);

  localparam int OUT_WIDTH = $clog2(MAX_OUT + 1);

  localparam logic [CMD_WIDTH-1:0] OP_SETUP = CMD_WIDTH'(8'h01);
  localparam logic [CMD_WIDTH-1:0] OP_RUN   = CMD_WIDTH'(8'h02);
  localparam logic [CMD_WIDTH-1:0] OP_WAIT  = CMD_WIDTH'(8'h03);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [DIF_WIDTH-1:0] cmd_reg;
  logic [CNT_WIDTH-1:0] remaining;
  logic [OUT_WIDTH-1:0] outstanding;
  logic [OUT_WIDTH-1:0] outstanding_next;

  logic                 dif_rd;
  logic                 stf_rd;
  logic                 ret;
  logic                 load_mux;
  logic                 load_cnt;
  logic                 set_err_cmd;
  logic                 timeout_hit;

  logic [CMD_WIDTH-1:0] opcode;
  logic [STF_WIDTH-1:0] payload;

  assign opcode  = cmd_reg[DIF_WIDTH-1 -: CMD_WIDTH];
  assign payload = cmd_reg[STF_WIDTH-1:0];

  // Read strobes are combinational so a FIFO word is consumed in the same
  // cycle the sequencer decides it can take it.
  assign dif_rd = (state == ST_IDLE) && !fifo.dififo_rdempty;
  assign stf_rd = (state == ST_RUN) && !fifo.sfifo_rdempty && !fifo.rfifo_wrfull &&
                  (outstanding < OUT_WIDTH'(MAX_OUT)) && (remaining != '0);

  assign fifo.dififo_rdreq = dif_rd;
  assign fifo.sfifo_rdreq  = stf_rd;
  assign busy              = (state != ST_IDLE);

  // A stray result with nothing in flight is dropped so the count cannot wrap.
  assign ret = fifo.rfifo_wrreq && (outstanding != '0);

  always_comb begin
    outstanding_next = outstanding;
    if (stf_rd && !ret)      outstanding_next = outstanding + OUT_WIDTH'(1);
    else if (!stf_rd && ret) outstanding_next = outstanding - OUT_WIDTH'(1);
  end

`ifdef DUT_SEQ_TIMEOUT_EN
  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_WIDTH-1:0] wd_cnt;
  logic                wd_expired;

  // wd_cnt holds the number of DRAIN cycles already completed, so the cycle
  // that sees TIMEOUT_CYCLES-1 is the last one allowed.
  assign wd_expired = (wd_cnt == WD_WIDTH'(TIMEOUT_CYCLES - 1));
`endif

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    load_mux    = 1'b0;
    load_cnt    = 1'b0;
    set_err_cmd = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE:   if (dif_rd) state_next = ST_FETCH;
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_SETUP: begin
            load_mux   = 1'b1;
            state_next = ST_IDLE;
          end
          OP_RUN: begin
            load_cnt   = 1'b1;
            state_next = (payload[CNT_WIDTH-1:0] == '0) ? ST_IDLE : ST_RUN;
          end
          OP_WAIT: state_next = ST_DRAIN;
          default: begin
            set_err_cmd = 1'b1;
            state_next  = ST_IDLE;
          end
        endcase
      end
      ST_RUN: begin
        // Leave on the cycle that issues the final read.
        if ((remaining == '0) || (stf_rd && remaining == CNT_WIDTH'(1)))
          state_next = ST_IDLE;
      end
      ST_DRAIN: begin
        if (outstanding_next == '0) begin
          state_next = ST_IDLE;
        end
`ifdef DUT_SEQ_TIMEOUT_EN
        else if (wd_expired) begin
          timeout_hit = 1'b1;
          state_next  = ST_IDLE;
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock_gated or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cmd_reg     <= '0;
      mux_config  <= '0;
      mux_load    <= 1'b0;
      remaining   <= '0;
      outstanding <= '0;
      err_cmd     <= 1'b0;
    end else begin
      state    <= state_next;
      mux_load <= load_mux;
      if (state == ST_FETCH) cmd_reg <= fifo.dififo_data;
      if (load_mux)          mux_config <= payload;
      if (load_cnt)          remaining <= payload[CNT_WIDTH-1:0];
      else if (stf_rd)       remaining <= remaining - CNT_WIDTH'(1);
      outstanding <= timeout_hit ? '0 : outstanding_next;
      if (set_err_cmd)       err_cmd <= 1'b1;
    end
  end

`ifdef DUT_SEQ_TIMEOUT_EN
  always_ff @(posedge clock_gated or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state_next == ST_DRAIN && state != ST_DRAIN) wd_cnt <= '0;
      else if (state == ST_DRAIN)                      wd_cnt <= wd_cnt + WD_WIDTH'(1);
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dut_seq.sv
// -----------------------------------------------------------------------------
// tb_dut_seq: self-checking bench for dut_seq. A cycle task drives the FIFO
// side after each rising edge and samples the sequencer on the falling edge.
// Command words come from a queue; mux programming expectations are pushed
// when a SETUP word is handed over and popped when mux_load appears; every
// stimulus read schedules a result write a fixed latency later.
// The DUT_SEQ_TIMEOUT_EN build option is honoured by the timeout scenario.
// -----------------------------------------------------------------------------
module tb_dut_seq;

  localparam int STF_WIDTH      = 24;
  localparam int CMD_WIDTH      = 8;
  localparam int DIF_WIDTH      = 32;
  localparam int CNT_WIDTH      = 16;
  localparam int MAX_OUT        = 4;
  localparam int TIMEOUT_CYCLES = 16;

  localparam logic [DIF_WIDTH-1:0] WAIT_CMD = 32'h0300_0000;

  logic                 clock_gated = 1'b0;
  logic                 reset_n     = 1'b1;
  logic [STF_WIDTH-1:0] mux_config;
  logic                 mux_load;
  logic                 busy;
  logic                 err_cmd;
  logic                 err_timeout;

  dut_seq_if #(.DIF_WIDTH(DIF_WIDTH)) fifo ();

  dut_seq #(
    .STF_WIDTH     (STF_WIDTH),
    .CMD_WIDTH     (CMD_WIDTH),
    .DIF_WIDTH     (DIF_WIDTH),
    .CNT_WIDTH     (CNT_WIDTH),
    .MAX_OUT       (MAX_OUT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_dut (
    .clock_gated(clock_gated),
    .reset_n    (reset_n),
    .fifo       (fifo.master),
    .mux_config (mux_config),
    .mux_load   (mux_load),
    .busy       (busy),
    .err_cmd    (err_cmd),
    .err_timeout(err_timeout)
  );

  always #5 clock_gated = ~clock_gated;

  typedef struct {
    logic [STF_WIDTH-1:0] value;
    int                   cycle;
  } mux_exp_t;

  int                   checks = 0;
  int                   errors = 0;
  int                   cyc = 0;
  logic [DIF_WIDTH-1:0] cmd_q[$];
  mux_exp_t             mux_q[$];
  int                   res_q[$];
  logic [STF_WIDTH-1:0] mux_model = '0;
  int                   latency = 3;
  bit                   no_return = 1'b0;
  bit                   stim_empty = 1'b0;
  bit                   wr_full = 1'b0;
  bit                   data_pend = 1'b0;
  logic [DIF_WIDTH-1:0] data_word = '0;
  int                   out_model = 0;
  int                   out_max = 0;
  int                   reads = 0;
  int                   results = 0;
  int                   loads = 0;
  bit                   rd_cmd_s = 1'b0;
  bit                   rd_stim_s = 1'b0;
  bit                   wr_now = 1'b0;
  int                   last_pop_cycle = -1;
  logic [DIF_WIDTH-1:0] last_pop_word = '0;

  // One clock cycle: drive after the rising edge, sample on the falling edge.
  task automatic step();
    int       due;
    mux_exp_t e;
    @(posedge clock_gated);
    #1;
    cyc++;
    if (data_pend) begin
      fifo.dififo_data = data_word;
      data_pend        = 1'b0;
    end
    fifo.dififo_rdempty = (cmd_q.size() == 0);
    fifo.sfifo_rdempty  = stim_empty;
    fifo.rfifo_wrfull   = wr_full;
    wr_now = 1'b0;
    if (res_q.size() != 0 && res_q[0] <= cyc) begin
      due     = res_q.pop_front();
      wr_now  = 1'b1;
      results++;
    end
    fifo.rfifo_wrreq = wr_now;

    @(negedge clock_gated);
    rd_cmd_s  = fifo.dififo_rdreq;
    rd_stim_s = fifo.sfifo_rdreq;

    if (rd_cmd_s) begin
      checks++;
      if (cmd_q.size() == 0) begin
        errors++;
        $display("FAIL cmd_rd_empty: dififo_rdreq=1 with command FIFO empty at cycle %0d", cyc);
      end else begin
        data_word      = cmd_q.pop_front();
        data_pend      = 1'b1;
        last_pop_word  = data_word;
        last_pop_cycle = cyc;
        if (data_word[DIF_WIDTH-1 -: CMD_WIDTH] == 8'h01) begin
          e.value = data_word[STF_WIDTH-1:0];
          e.cycle = cyc + 3;
          mux_q.push_back(e);
        end
      end
    end

    if (rd_stim_s) begin
      checks++;
      if (stim_empty || wr_full || out_model >= MAX_OUT) begin
        errors++;
        $display("FAIL read_gate: sfifo_rdreq=1 with empty=%0b full=%0b outstanding=%0d at cycle %0d",
                 stim_empty, wr_full, out_model, cyc);
      end
      reads++;
      if (!no_return) res_q.push_back(cyc + latency);
    end
    out_model = out_model + (rd_stim_s ? 1 : 0) - (wr_now ? 1 : 0);
    if (out_model > out_max) out_max = out_model;

    checks++;
    if (mux_load) begin
      loads++;
      if (mux_q.size() == 0) begin
        errors++;
        $display("FAIL mux_load_unexpected: mux_load=1 mux_config=%0h with no pending setup at cycle %0d",
                 mux_config, cyc);
      end else begin
        e = mux_q.pop_front();
        if (mux_config !== e.value || cyc != e.cycle) begin
          errors++;
          $display("FAIL mux_setup: got %0h at cycle %0d, expected %0h at cycle %0d",
                   mux_config, cyc, e.value, e.cycle);
        end
        mux_model = e.value;
      end
    end else if (mux_config !== mux_model) begin
      errors++;
      $display("FAIL mux_hold: mux_config=%0h expected %0h at cycle %0d", mux_config, mux_model, cyc);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(!busy && !rd_cmd_s && cmd_q.size() == 0 && res_q.size() == 0 && !data_pend)
               && n < budget);
    checks++;
    if (busy || cmd_q.size() != 0 || res_q.size() != 0) begin
      errors++;
      $display("FAIL %s_idle: not idle after %0d cycles (busy=%0b cmds=%0d results=%0d)",
               name, budget, busy, cmd_q.size(), res_q.size());
    end
  endtask

  task automatic apply_reset();
    @(posedge clock_gated);
    #3;
    reset_n = 1'b0;
    cmd_q.delete();
    mux_q.delete();
    res_q.delete();
    mux_model           = '0;
    out_model           = 0;
    data_pend           = 1'b0;
    fifo.dififo_rdempty = 1'b1;
    fifo.rfifo_wrreq    = 1'b0;
    #1;
    checks++;
    if (mux_config !== '0 || mux_load !== 1'b0 || busy !== 1'b0 || err_cmd !== 1'b0 ||
        err_timeout !== 1'b0 || fifo.sfifo_rdreq !== 1'b0 || fifo.dififo_rdreq !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: mux_config=%0h mux_load=%0b busy=%0b err_cmd=%0b err_timeout=%0b sreq=%0b dreq=%0b, expected all 0",
               mux_config, mux_load, busy, err_cmd, err_timeout, fifo.sfifo_rdreq, fifo.dififo_rdreq);
    end
    repeat (2) @(posedge clock_gated);
    @(negedge clock_gated);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    fifo.dififo_data    = '0;
    fifo.dififo_rdempty = 1'b1;
    fifo.sfifo_rdempty  = 1'b0;
    fifo.rfifo_wrreq    = 1'b0;
    fifo.rfifo_wrfull   = 1'b0;
    #1;
    apply_reset();
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || rd_stim_s || rd_cmd_s || mux_config !== '0) begin
      errors++;
      $display("FAIL reset_idle: busy=%0b sreq=%0b dreq=%0b mux_config=%0h, expected 0/0/0/0",
               busy, rd_stim_s, rd_cmd_s, mux_config);
    end
  endtask

  task automatic test_setup_mux();
    int loads0 = loads;
    cmd_q.push_back(32'h0100_A5A5);
    wait_idle(40, "setup");
    checks++;
    if (mux_config !== 24'h00A5A5 || loads - loads0 != 1 || mux_q.size() != 0) begin
      errors++;
      $display("FAIL setup_mux: mux_config=%0h loads=%0d pending=%0d, expected a5a5/1/0",
               mux_config, loads - loads0, mux_q.size());
    end
  endtask

  task automatic test_run_basic();
    int n = 0;
    latency = 3;
    reads   = 0;
    results = 0;
    out_max = 0;
    cmd_q.push_back(32'h0200_0005);
    do begin
      step();
      n++;
    end while (!(rd_stim_s && reads == 5) && n < 60);
    step();
    checks++;
    if (reads != 5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_last_read: reads=%0d busy=%0b after final read, expected 5/0", reads, busy);
    end
    wait_idle(40, "run");
    checks++;
    if (reads != 5 || results != 5 || out_max > MAX_OUT) begin
      errors++;
      $display("FAIL run_basic: reads=%0d results=%0d max_outstanding=%0d, expected 5/5/<=4",
               reads, results, out_max);
    end
  endtask

  task automatic test_back_to_back();
    latency = 12;
    reads   = 0;
    results = 0;
    out_max = 0;
    cmd_q.push_back(32'h0200_0008);
    cmd_q.push_back(32'h0100_1234);
    wait_idle(150, "b2b");
    checks++;
    if (reads != 8 || results != 8 || out_max != MAX_OUT || mux_config !== 24'h001234) begin
      errors++;
      $display("FAIL back_to_back: reads=%0d results=%0d max_outstanding=%0d mux=%0h, expected 8/8/4/1234",
               reads, results, out_max, mux_config);
    end
  endtask

  task automatic test_stall();
    latency = 3;
    reads   = 0;
    wr_full = 1'b1;
    cmd_q.push_back(32'h0200_0003);
    repeat (14) step();
    checks++;
    if (reads != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_wrfull: reads=%0d busy=%0b, expected 0/1", reads, busy);
    end
    wr_full    = 1'b0;
    stim_empty = 1'b1;
    repeat (6) step();
    checks++;
    if (reads != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_empty: reads=%0d busy=%0b, expected 0/1", reads, busy);
    end
    stim_empty = 1'b0;
    wait_idle(40, "stall");
    checks++;
    if (reads != 3) begin
      errors++;
      $display("FAIL stall_release: reads=%0d expected 3", reads);
    end
  endtask

  task automatic test_wait_drain();
    int w = -1;
    int n = 0;
    latency = 20;
    reads   = 0;
    results = 0;
    cmd_q.push_back(32'h0200_0002);
    cmd_q.push_back(WAIT_CMD);
    do begin
      step();
      n++;
      if (rd_cmd_s && last_pop_word == WAIT_CMD) w = cyc;
      if (w >= 0 && cyc > w) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL drain_busy: busy=%0b with %0d of 2 results at cycle %0d, expected 1",
                   busy, results, cyc);
        end
      end
    end while (results < 2 && n < 100);
    step();
    checks++;
    if (busy !== 1'b0 || results != 2 || w < 0) begin
      errors++;
      $display("FAIL drain_exit: busy=%0b results=%0d wait_fetched=%0b, expected 0/2/1",
               busy, results, w >= 0);
    end
  endtask

  task automatic test_bad_opcode();
    checks++;
    if (err_cmd !== 1'b0) begin
      errors++;
      $display("FAIL err_cmd_pre: err_cmd=%0b expected 0", err_cmd);
    end
    reads = 0;
    cmd_q.push_back(32'h7F12_3456);
    cmd_q.push_back(32'h0100_0011);
    cmd_q.push_back(32'h0200_0000);
    wait_idle(40, "badop");
    checks++;
    if (err_cmd !== 1'b1 || mux_config !== 24'h000011 || reads != 0) begin
      errors++;
      $display("FAIL bad_opcode: err_cmd=%0b mux_config=%0h reads=%0d, expected 1/11/0",
               err_cmd, mux_config, reads);
    end
  endtask

  task automatic test_timeout();
    int w = -1;
    int n = 0;
    no_return = 1'b1;
    reads     = 0;
    cmd_q.push_back(32'h0200_0001);
    cmd_q.push_back(WAIT_CMD);
    do begin
      step();
      n++;
      if (rd_cmd_s && last_pop_word == WAIT_CMD) w = cyc;
    end while (w < 0 && n < 40);
`ifdef DUT_SEQ_TIMEOUT_EN
    while (cyc < w + 18 && n < 80) begin
      step();
      n++;
      checks++;
      if (err_timeout !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL timeout_early: err_timeout=%0b busy=%0b at cycle %0d after wait, expected 0/1",
                 err_timeout, busy, cyc - w);
      end
    end
    step();
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || reads != 1) begin
      errors++;
      $display("FAIL timeout_fire: err_timeout=%0b busy=%0b reads=%0d, expected 1/0/1",
               err_timeout, busy, reads);
    end
    out_model = 0;
    no_return = 1'b0;
    latency   = 12;
    reads     = 0;
    cmd_q.push_back(32'h0200_0004);
    repeat (12) step();
    checks++;
    if (reads != 4) begin
      errors++;
      $display("FAIL timeout_clears_outstanding: reads=%0d before any result, expected 4", reads);
    end
    wait_idle(40, "timeout");
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: err_timeout=%0b expected 1", err_timeout);
    end
`else
    repeat (40) step();
    checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1 || reads != 1 || w < 0) begin
      errors++;
      $display("FAIL drain_forever: err_timeout=%0b busy=%0b reads=%0d, expected 0/1/1",
               err_timeout, busy, reads);
    end
    no_return = 1'b0;
    apply_reset();
`endif
  endtask

  task automatic test_reset_abort();
    bit bad = 1'b0;
    latency    = 3;
    reads      = 0;
    stim_empty = 1'b1;
    cmd_q.push_back(32'h7F00_0000);
    cmd_q.push_back(32'h0100_0F0F);
    cmd_q.push_back(32'h0200_000A);
    repeat (14) step();
    checks++;
    if (busy !== 1'b1 || reads != 0 || err_cmd !== 1'b1 || mux_config !== 24'h000F0F) begin
      errors++;
      $display("FAIL abort_pre: busy=%0b reads=%0d err_cmd=%0b mux=%0h, expected 1/0/1/f0f",
               busy, reads, err_cmd, mux_config);
    end
    apply_reset();
    stim_empty = 1'b0;
    repeat (15) begin
      step();
      if (busy !== 1'b0 || rd_stim_s || rd_cmd_s) bad = 1'b1;
    end
    checks++;
    if (bad || reads != 0) begin
      errors++;
      $display("FAIL abort_post: strobes or busy after reset (reads=%0d), expected none", reads);
    end
    cmd_q.push_back(32'h0200_0002);
    wait_idle(40, "abort");
    checks++;
    if (reads != 2) begin
      errors++;
      $display("FAIL abort_restart: reads=%0d expected 2", reads);
    end
  endtask

  initial begin
    test_reset();
    test_setup_mux();
    test_run_basic();
    test_back_to_back();
    test_stall();
    test_wait_drain();
    test_bad_opcode();
    test_timeout();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation exceeded time limit");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/dut_seq.md
DUT_SEQ -- requirements
Module: dut_seq

Interface
REQ-001 Parameter STF_WIDTH, default 24: stimulus/mux word width.
REQ-002 Parameter CMD_WIDTH, default 8: command opcode width.
REQ-003 Parameter DIF_WIDTH, default 32: command word width; opcode is bits [DIF_WIDTH-1 -: CMD_WIDTH], payload is bits [STF_WIDTH-1:0].
REQ-004 Parameter CNT_WIDTH, default 16: vector count width.
REQ-005 Parameter MAX_OUT, default 4: maximum number of stimulus reads not yet matched by a result write.
REQ-006 Parameter TIMEOUT_CYCLES, default 1024: drain watchdog limit.
REQ-007 Port clock_gated, input, 1: clock; all state changes on its rising edge.
REQ-008 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-009 Port dififo_data, input, DIF_WIDTH: command FIFO read data, valid the cycle after dififo_rdreq.
REQ-010 Port dififo_rdempty, input, 1: command FIFO empty.
REQ-011 Port dififo_rdreq, output, 1: command FIFO read strobe.
REQ-012 Port sfifo_rdempty, input, 1: stimulus FIFO empty.
REQ-013 Port sfifo_rdreq, output, 1: stimulus FIFO read strobe, one per vector.
REQ-014 Port rfifo_wrreq, input, 1: result FIFO write strobe from the DUT datapath; retires one outstanding vector.
REQ-015 Port rfifo_wrfull, input, 1: result FIFO full.
REQ-016 Port mux_config, output, STF_WIDTH: per-pin clock-mux select, registered.
REQ-017 Port mux_load, output, 1: one-cycle pulse on the cycle mux_config changes.
REQ-018 Port busy, output, 1: high in every state except IDLE.
REQ-019 Port err_cmd, output, 1: sticky flag for an unknown opcode.
REQ-020 Port err_timeout, output, 1: sticky flag for a drain watchdog expiry.

Function
REQ-021 The FSM SHALL have the states IDLE, FETCH, DECODE, RUN and DRAIN.
REQ-022 IDLE: dififo_rdreq = ~dififo_rdempty (combinational); if asserted, next state FETCH.
REQ-023 FETCH: latch dififo_data into the command register; next state DECODE; dififo_rdreq stays 0 outside IDLE.
REQ-024 DECODE opcode 0x01 (SETUP_MUXES): mux_config <= payload, mux_load = 1 for one cycle, next state IDLE.
REQ-025 DECODE opcode 0x02 (RUN): remaining <= payload[CNT_WIDTH-1:0]; next state is IDLE if the payload is 0, otherwise RUN.
REQ-026 DECODE opcode 0x03 (WAIT): next state DRAIN.
REQ-027 DECODE, any other opcode: err_cmd <= 1, next state IDLE, no other effect.
REQ-028 RUN: sfifo_rdreq = ~sfifo_rdempty & ~rfifo_wrfull & (outstanding < MAX_OUT) & (remaining != 0), combinational.
REQ-029 RUN: each sfifo_rdreq decrements remaining; the cycle that issues the last read transitions to IDLE.
REQ-030 outstanding counter, width clog2(MAX_OUT+1): +1 on sfifo_rdreq, -1 on rfifo_wrreq, unchanged when both occur in the same cycle.
REQ-031 outstanding SHALL NOT underflow; rfifo_wrreq while outstanding = 0 is ignored.
REQ-032 DRAIN: next state IDLE when outstanding = 0 (checked after the current cycle's update); no new reads are issued in DRAIN.
REQ-033 RUN commands are not implicitly drained; a following SETUP_MUXES takes effect while vectors may still be in flight.
REQ-034 Stalls: sfifo_rdempty or rfifo_wrfull in RUN holds state and counters with no timeout.

Reset
REQ-035 While reset_n = 0: state = IDLE, mux_config = 0, mux_load = 0, remaining = 0, outstanding = 0, err_cmd = 0, err_timeout = 0, command register = 0.
REQ-036 Reset asserted mid-RUN or mid-DRAIN aborts immediately; no further strobes are issued after deassertion until a new command is fetched.
REQ-037 The err flags clear only on reset.

Configuration
REQ-038 Macro DUT_SEQ_TIMEOUT_EN defined: a watchdog counter clears on entry to DRAIN and increments each DRAIN cycle.
REQ-039 With DUT_SEQ_TIMEOUT_EN, reaching TIMEOUT_CYCLES with outstanding != 0 sets err_timeout, zeroes outstanding and moves to IDLE.
REQ-040 Macro DUT_SEQ_TIMEOUT_EN undefined: no watchdog logic, err_timeout is tied to 0, and DRAIN waits indefinitely.

Verification
REQ-041 Command 0x01_00A5A5 -> mux_config = 0x00A5A5 three cycles after dififo_rdreq; mux_load high for exactly 1 cycle.
REQ-042 RUN with payload 5, FIFOs non-empty and not full, results returned 3 cycles after each read -> exactly 5 sfifo_rdreq pulses; outstanding never exceeds 4; state IDLE after the 5th read.
REQ-043 RUN with payload 3, rfifo_wrfull held high for 10 cycles -> zero reads during those cycles, then 3 reads once wrfull drops.
REQ-044 RUN with payload 2, then WAIT with results delayed 20 cycles -> busy stays high until the 2nd rfifo_wrreq, then IDLE.
REQ-045 Opcode 0x7F -> err_cmd = 1, mux_config unchanged, next command processed normally; RUN with payload 0 -> no reads.
REQ-046 With DUT_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 16, WAIT with 1 result never returned -> err_timeout = 1 after 16 DRAIN cycles, outstanding = 0.
